// File: rtl/button_event.sv
// Button event classifier: turns a debounced button level into press/release
// pulses and classifies each press sequence as short, long or double.
// The release pulse port is named `released` because `release` is a reserved
// word in SystemVerilog.
module button_event #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LONG_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES  = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press,
  output logic released,
  output logic short_press,
  output logic long_press,
  output logic double_press
);

  typedef enum logic [2:0] {
    StLockout,
    StIdle,
    StPressed,
    StWaitSecond,
    StSecondPressed,
    StLongHeld
  } state_e;

  localparam logic [WIDTH-1:0] LongLast = WIDTH'(LONG_CYCLES - 1);
  localparam logic [WIDTH-1:0] GapLast  = WIDTH'(GAP_CYCLES - 1);
  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic             in_q;
  // in_q holds its reset value for the first edge after reset; LOCKOUT must
  // not treat that forced 0 as a genuine release.
  logic             in_valid_q;

  // Register the button level; the FSM only ever looks at in_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q       <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      in_q       <= in;
      in_valid_q <= 1'b1;
    end
  end

  // Classification FSM with registered one-cycle output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLockout;
      count_q      <= '0;
      press        <= 1'b0;
      released     <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
    end else begin
      press        <= 1'b0;
      released     <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      unique case (state_q)
        StLockout: begin
          if (in_valid_q && !in_q) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          if (in_q) begin
            state_q <= StPressed;
            press   <= 1'b1;
            count_q <= '0;
          end
        end
        StPressed: begin
          if (!in_q) begin
            state_q  <= StWaitSecond;
            released <= 1'b1;
            count_q  <= '0;
          end else if (count_q == LongLast) begin
            state_q    <= StLongHeld;
            long_press <= 1'b1;
          end else begin
            count_q <= count_q + CountOne;
          end
        end
        StWaitSecond: begin
          // A press on the final gap cycle still counts as the second press.
          if (in_q) begin
            state_q <= StSecondPressed;
            press   <= 1'b1;
            count_q <= '0;
          end else if (count_q == GapLast) begin
            state_q     <= StIdle;
            short_press <= 1'b1;
            count_q     <= '0;
          end else begin
            count_q <= count_q + CountOne;
          end
        end
        StSecondPressed: begin
          if (!in_q) begin
            state_q      <= StIdle;
            released     <= 1'b1;
            double_press <= 1'b1;
            count_q      <= '0;
          end else if (count_q == LongLast) begin
            state_q    <= StLongHeld;
            long_press <= 1'b1;
          end else begin
            count_q <= count_q + CountOne;
          end
        end
        StLongHeld: begin
          if (!in_q) begin
            state_q  <= StIdle;
            released <= 1'b1;
            count_q  <= '0;
          end
        end
        default: begin
          state_q <= StLockout;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with WIDTH=8, LONG_CYCLES=8, GAP_CYCLES=4.
// Each table row: at a falling edge the outputs are compared to exp, then in
// is driven to in_v. A press from in rising at row r shows up at row r+2.
module tb_button_event;

  typedef struct {
    logic       in_v;
    logic [4:0] exp;  // {press, released, short, long, double}
  } vec_t;

  localparam logic [4:0] P = 5'b10000;
  localparam logic [4:0] R = 5'b01000;
  localparam logic [4:0] S = 5'b00100;
  localparam logic [4:0] L = 5'b00010;
  localparam logic [4:0] D = 5'b00001;
  localparam logic [4:0] Z = 5'b00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic press, released, short_press, long_press, double_press;

  int total = 0;
  int bad   = 0;

  vec_t tab[128];
  int   n_rows = 0;

  button_event #(
    .WIDTH      (8),
    .LONG_CYCLES(8),
    .GAP_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in          (in),
    .press       (press),
    .released    (released),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {press, released, short_press, long_press, double_press};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b (press,rel,short,long,dbl)", name, got, want);
    end
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      tab[n_rows].in_v = v;
      tab[n_rows].exp  = Z;
      n_rows++;
    end
  endtask

  task automatic mark(input int idx, input logic [4:0] bits);
    tab[idx].exp = tab[idx].exp | bits;
  endtask

  initial begin
    // Idle after reset.
    hold(1'b0, 4);                                         // rows 0-3
    // Short press: high 3 rows.
    hold(1'b1, 3); hold(1'b0, 12);                         // rows 4-18
    mark(6, P); mark(9, R); mark(13, S);
    // Long press: high 20 rows.
    hold(1'b1, 20); hold(1'b0, 6);                         // rows 19-44
    mark(21, P); mark(29, L); mark(41, R);
    // Double press: high 2, low 2, high 2.
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 8);  // rows 45-58
    mark(47, P); mark(49, R); mark(51, P); mark(53, R | D);
    // Gap boundary, second press lands on the last gap cycle: double.
    hold(1'b1, 2); hold(1'b0, 4); hold(1'b1, 2); hold(1'b0, 8);  // rows 59-74
    mark(61, P); mark(63, R); mark(67, P); mark(69, R | D);
    // Gap boundary, one cycle later: short, then a fresh press.
    hold(1'b1, 2); hold(1'b0, 5); hold(1'b1, 2); hold(1'b0, 10); // rows 75-93
    mark(77, P); mark(79, R); mark(83, S); mark(84, P); mark(86, R); mark(90, S);
    // Long second press: high 2, low 1, high 10.
    hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 10); hold(1'b0, 8); // rows 94-114
    mark(96, P); mark(98, R); mark(99, P); mark(107, L); mark(109, R);

    // Reset state, with the reset asserted.
    repeat (3) @(negedge clk);
    check("reset_state", outs(), Z);
    rst = 1'b0;

    for (int i = 0; i < n_rows; i++) begin
      @(negedge clk);
      check($sformatf("row%0d", i), outs(), tab[i].exp);
      in = tab[i].in_v;
    end

    // Reset mid-press, button held through reset release: locked out.
    @(negedge clk); in = 1'b1;
    @(negedge clk);
    @(negedge clk); check("pre_reset_press", outs(), P);
    @(negedge clk); rst = 1'b1;
    #1 check("reset_async_clear", outs(), Z);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); check($sformatf("lockout_held%0d", i), outs(), Z);
    end
    in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check($sformatf("lockout_rel%0d", i), outs(), Z);
    end
    in = 1'b1;
    @(negedge clk); check("relock_press_early", outs(), Z);
    @(negedge clk); check("relock_press", outs(), P);
    in = 1'b0;
    @(negedge clk); check("abort_pre_release", outs(), Z);
    @(negedge clk); check("abort_release", outs(), R);
    // Reset while waiting for a second press: the short pulse is dropped.
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); check($sformatf("abort_quiet%0d", i), outs(), Z);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the bit width of the internal cycle counter.
REQ-002 SHALL have parameter LONG_CYCLES, default 50000, giving the hold time in clk cycles that classifies a press as long.
REQ-003 SHALL have parameter GAP_CYCLES, default 20000, giving the maximum release-to-second-press window in clk cycles for a double press.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in, input, 1 bit: debounced button level in the clk domain, where 1 means pressed.
REQ-007 SHALL have port press, output, 1 bit: one-cycle pulse on each accepted press.
REQ-008 SHALL have port release, output, 1 bit: one-cycle pulse on each accepted release.
REQ-009 SHALL have port short_press, output, 1 bit: one-cycle pulse when a single short press is confirmed.
REQ-010 SHALL have port long_press, output, 1 bit: one-cycle pulse when the hold time reaches LONG_CYCLES.
REQ-011 SHALL have port double_press, output, 1 bit: one-cycle pulse when the second short press of a double press is released.

Function
REQ-012 SHALL register in into in_q every cycle; the FSM SHALL consume only in_q, never in directly.
REQ-013 SHALL implement the states LOCKOUT, IDLE, PRESSED, WAIT_SECOND, SECOND_PRESSED and LONG_HELD.
REQ-014 SHALL drive all outputs from registers; each pulse SHALL be high for exactly one cycle, in the cycle after the edge that takes the transition.
REQ-015 SHALL take the following transition from LOCKOUT: in_q=0 -> IDLE, with no pulse.
REQ-016 SHALL take the following transition from IDLE: in_q=1 -> PRESSED, with press pulse and count cleared to 0.
REQ-017 SHALL, in PRESSED with in_q=1, increment count each cycle; at count==LONG_CYCLES-1 it SHALL go to LONG_HELD with a long_press pulse.
REQ-018 SHALL take the following transition from PRESSED: in_q=0 -> WAIT_SECOND, with release pulse and count cleared.
REQ-019 SHALL, in WAIT_SECOND with in_q=1, go to SECOND_PRESSED with a press pulse and count cleared.
REQ-020 SHALL, in WAIT_SECOND with in_q=0, increment count; at count==GAP_CYCLES-1 it SHALL go to IDLE with a short_press pulse.
REQ-021 SHALL resolve WAIT_SECOND at count==GAP_CYCLES-1 with in_q=1 in favour of the press: go to SECOND_PRESSED, no short_press.
REQ-022 SHALL, in SECOND_PRESSED with in_q=0, go to IDLE with release and double_press pulses in the same cycle.
REQ-023 SHALL, in SECOND_PRESSED with in_q=1, increment count; at count==LONG_CYCLES-1 it SHALL go to LONG_HELD with a long_press pulse, and no double_press is ever issued for that sequence.
REQ-024 SHALL take the following transition from LONG_HELD: in_q=0 -> IDLE, with release pulse.
REQ-025 SHALL ensure count never exceeds max(LONG_CYCLES, GAP_CYCLES)-1 and never wraps; legal parameters are 2 <= LONG_CYCLES, GAP_CYCLES <= 2^WIDTH.
REQ-026 SHALL ensure short_press, long_press and double_press are mutually exclusive per press sequence, and that at most one of them fires per sequence.
REQ-027 SHALL produce press latency of 2 rising edges from in rising to press high; long_press SHALL rise LONG_CYCLES cycles after press.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state=LOCKOUT, count=0, in_q=0 and all outputs to 0.
REQ-029 SHALL, if in is held high through reset release, stay in LOCKOUT until in is released, producing no press, release or long_press.
REQ-030 SHALL, on reset asserted mid-sequence, abort the sequence with no pending pulse emitted after rst deasserts.

Verification (WIDTH=8, LONG_CYCLES=8, GAP_CYCLES=4)
REQ-031 SHALL verify a short press: in high 3 cycles, then low -> press, release, and short_press 4 cycles after release, each 1 cycle wide.
REQ-032 SHALL verify a long press: in high 20 cycles -> press, long_press 8 cycles after press, release on drop; no short_press.
REQ-033 SHALL verify a double press: high 2, low 2, high 2, low -> press x2, release x2, double_press coincident with the second release; no short_press.
REQ-034 SHALL verify the gap boundary: second press arriving so that in_q=1 exactly at count==3 -> double path taken; arriving one cycle later -> short_press, then a new press.
REQ-035 SHALL verify reset with in held high: rst pulsed while in=1 -> no outputs until in falls and rises again, then press.
REQ-036 SHALL verify a long second press: high 2, low 1, high 10 -> long_press, no double_press, release on drop.
